// File: rtl/pg_multi_core_if.sv
// pg_multi_core_if: control/config/output bundle of the multi-channel pulse core
// master drives start/stop/update requests and config, slave (the core) returns
// o_pulse, o_sync, o_busy and o_upd_ack.
interface pg_multi_core_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24
);
  logic                    i_start;
  logic                    i_stop;
  logic                    i_update;
  logic [CNT_W-1:0]        i_period;
  logic [15:0]             i_burst_len;
  logic [NUM_CH*CNT_W-1:0] i_st;
  logic [NUM_CH*CNT_W-1:0] i_end;
  logic [NUM_CH-1:0]       o_pulse;
  logic                    o_sync;
  logic                    o_busy;
  logic                    o_upd_ack;
  modport master (
    output i_start, i_stop, i_update, i_period, i_burst_len, i_st, i_end,
    input  o_pulse, o_sync, o_busy, o_upd_ack
  );
  modport slave (
    input  i_start, i_stop, i_update, i_period, i_burst_len, i_st, i_end,
    output o_pulse, o_sync, o_busy, o_upd_ack
  );
endinterface

// File: rtl/pg_multi_core.sv
// pg_multi_core: NUM_CH pulse trains from one shared period counter with shadowed config
// Ports: i_clk core clock, i_res_n async active-low reset, pg (pg_multi_core_if.slave)
// carrying start/stop/update requests, period/burst/window config and the registered
// outputs. Define PG_BURST_EN to honour i_burst_len (finite bursts); otherwise runs
// are continuous until stopped.
module pg_multi_core #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24
) (
  input logic          i_clk,
  input logic          i_res_n,
  pg_multi_core_if.slave pg
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt, period_s;
  logic [CNT_W-1:0] st_s [NUM_CH];
  logic [CNT_W-1:0] end_s [NUM_CH];
  logic upd_pend, stop_pend;
  logic [NUM_CH-1:0] win;
  logic wrap, do_load, done;
  assign wrap = cnt == period_s;
  // an update arriving on the wrap cycle itself merges into that wrap's load
  assign do_load = (state == IDLE) ? (pg.i_start || pg.i_update) : (wrap && (upd_pend || pg.i_update));
`ifdef PG_BURST_EN
  logic [15:0] burst_s, pcnt;
  assign done = wrap && (stop_pend || pg.i_stop || (burst_s != 16'd0 && pcnt + 16'd1 == burst_s));
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      burst_s <= '0;
      pcnt    <= '0;
    end else begin
      if (do_load) burst_s <= pg.i_burst_len;
      pcnt <= (state == IDLE) ? 16'd0 : wrap ? pcnt + 16'd1 : pcnt;
    end
  end
`else
  logic unused_burst;
  assign unused_burst = ^pg.i_burst_len;
  assign done = wrap && (stop_pend || pg.i_stop);
`endif
  // st < end: plain window; st > end: window wraps through cnt = 0; st == end: empty
  always_comb begin
    win = '0;
    for (int k = 0; k < NUM_CH; k++)
      win[k] = (st_s[k] < end_s[k]) ? (cnt >= st_s[k] && cnt < end_s[k])
                                    : (st_s[k] > end_s[k] && (cnt >= st_s[k] || cnt < end_s[k]));
  end
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state        <= IDLE;
      cnt          <= '0;
      period_s     <= '0;
      upd_pend     <= 1'b0;
      stop_pend    <= 1'b0;
      pg.o_pulse   <= '0;
      pg.o_sync    <= 1'b0;
      pg.o_busy    <= 1'b0;
      pg.o_upd_ack <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        st_s[k]  <= '0;
        end_s[k] <= '0;
      end
    end else begin
      pg.o_upd_ack <= do_load;
      if (do_load) begin
        period_s <= pg.i_period;
        for (int k = 0; k < NUM_CH; k++) begin
          st_s[k]  <= pg.i_st[k*CNT_W +: CNT_W];
          end_s[k] <= pg.i_end[k*CNT_W +: CNT_W];
        end
      end
      if (state == IDLE) begin
        cnt        <= '0;
        upd_pend   <= 1'b0;
        stop_pend  <= 1'b0;
        pg.o_pulse <= '0;
        pg.o_sync  <= 1'b0;
        if (pg.i_start) begin
          state     <= RUN;
          pg.o_busy <= 1'b1;
        end
      end else begin
        pg.o_pulse <= win;
        pg.o_sync  <= cnt == '0;
        cnt        <= wrap ? '0 : cnt + 1'b1;
        upd_pend   <= !wrap && (upd_pend || pg.i_update);
        stop_pend  <= !wrap && (stop_pend || pg.i_stop);
        if (done) begin
          state     <= IDLE;
          pg.o_busy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pg_multi_core.sv
// tb_pg_multi_core: table-driven window checks, directed corner sequences and random runs vs a waveform model
module tb_pg_multi_core;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 24;
  logic clk = 1'b0;
  logic res_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int rs [NUM_CH];
  int re [NUM_CH];
  pg_multi_core_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();
  pg_multi_core #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (.i_clk(clk), .i_res_n(res_n), .pg(bus));
  always #5 clk = ~clk;
  typedef struct { int p; int s; int e; int mask; } vec_t;
  vec_t tbl [8];
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  function automatic int obs();
    return int'({bus.o_upd_ack, bus.o_busy, bus.o_sync, bus.o_pulse});
  endfunction
  function automatic int pack(bit ack, bit busy, bit sync, int pulse);
    return (int'(ack) << 6) | (int'(busy) << 5) | (int'(sync) << 4) | pulse;
  endfunction
  function automatic bit win(int c, int s, int e);
    if (s < e) return c >= s && c < e;
    if (s > e) return c >= s || c < e;
    return 1'b0;
  endfunction
  task automatic cfg(int p, int b);
    bus.i_period    = CNT_W'(p);
    bus.i_burst_len = 16'(b);
    bus.i_st        = '0;
    bus.i_end       = '0;
  endtask
  task automatic set_ch(int k, int s, int e);
    bus.i_st[k*CNT_W +: CNT_W]  = CNT_W'(s);
    bus.i_end[k*CNT_W +: CNT_W] = CNT_W'(e);
  endtask
  task automatic start_run();
    bus.i_start = 1'b1;
    cyc();
    bus.i_start = 1'b0;
  endtask
  task automatic stop_and_idle();
    bus.i_stop = 1'b1;
    cyc();
    bus.i_stop = 1'b0;
    for (int n = 0; n < 60 && bus.o_busy; n++) cyc();
    chk("stop_idle_busy", int'(bus.o_busy), 0);
    cyc();
    cyc();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{9, 2, 5, 'h01c};
    tbl[1] = '{9, 8, 2, 'h303};
    tbl[2] = '{9, 4, 4, 0};
    tbl[3] = '{9, 12, 15, 0};
    tbl[4] = '{0, 0, 1, 1};
    tbl[5] = '{5, 3, 0, 'h038};
    tbl[6] = '{9, 0, 10, 'h3ff};
    tbl[7] = '{7, 6, 2, 'h0c3};
    bus.i_start = 1'b0;
    bus.i_stop = 1'b0;
    bus.i_update = 1'b0;
    cfg(0, 0);
    cyc();
    cyc();
    chk("reset_outputs", obs(), 0);
    res_n = 1'b1;
    cyc();
    chk("post_reset_idle", obs(), 0);
    // update while idle: ack next cycle, no run
    cfg(9, 0);
    set_ch(0, 2, 5);
    bus.i_update = 1'b1;
    cyc();
    bus.i_update = 1'b0;
    chk("idle_upd_ack", obs(), pack(1, 0, 0, 0));
    cyc();
    chk("idle_upd_ack_clear", obs(), 0);
    // stop alone in idle is ignored
    bus.i_stop = 1'b1;
    cyc();
    bus.i_stop = 1'b0;
    chk("idle_stop_ignored", obs(), 0);
    // basic start timing
    start_run();
    chk("start_t1", obs(), pack(1, 1, 0, 0));
    cyc();
    chk("start_t2", obs(), pack(0, 1, 1, 0));
    stop_and_idle();
    // window table
    foreach (tbl[i]) begin
      int m;
      m = 0;
      cfg(tbl[i].p, 0);
      set_ch(0, tbl[i].s, tbl[i].e);
      start_run();
      cyc();
      for (int c = 0; c <= tbl[i].p; c++) begin
        if (bus.o_pulse[0]) m |= 1 << c;
        cyc();
      end
      chk($sformatf("win_tbl%0d", i), m, tbl[i].mask);
      stop_and_idle();
    end
    // update mid-run at cnt = 3: old period completes, new 20-cycle period starts with ack
    cfg(9, 0);
    set_ch(0, 2, 5);
    start_run();
    for (int j = 1; j <= 45; j++) begin
      bit ack, sync, p0;
      ack = j == 1 || j == 11;
      sync = j == 2 || (j >= 12 && (j - 12) % 20 == 0);
      p0 = (j >= 2 && j <= 11) ? win(j - 2, 2, 5) : (j >= 12) ? ((j - 12) % 20 < 10) : 1'b0;
      chk($sformatf("upd_mid_j%0d", j), obs(), pack(ack, 1, sync, int'(p0)));
      bus.i_update = j == 4 || j == 6;
      if (j == 4) begin
        cfg(19, 0);
        set_ch(0, 0, 10);
      end
      cyc();
    end
    bus.i_update = 1'b0;
    stop_and_idle();
    // stop at cnt = 1: runs to the wrap, then idle
    cfg(9, 0);
    set_ch(0, 2, 5);
    start_run();
    for (int j = 1; j <= 13; j++) begin
      bit live;
      live = j >= 2 && j <= 11;
      chk($sformatf("stop_j%0d", j), obs(),
          pack(j == 1, j <= 10, j == 2, int'(live && win(j - 2, 2, 5))));
      bus.i_stop = j == 2;
      cyc();
    end
    bus.i_stop = 1'b0;
    // start and stop together in idle: start wins
    cfg(9, 0);
    bus.i_start = 1'b1;
    bus.i_stop = 1'b1;
    cyc();
    bus.i_start = 1'b0;
    bus.i_stop = 1'b0;
    for (int j = 1; j < 30; j++) cyc();
    chk("start_stop_running", int'(bus.o_busy), 1);
    stop_and_idle();
    // burst of 3 periods of 5 cycles
    begin
      int syncs, last;
      syncs = 0;
      last = 0;
      cfg(4, 3);
      start_run();
      for (int j = 1; j <= 30; j++) begin
        if (bus.o_sync) syncs++;
        if (bus.o_busy) last = j;
        cyc();
      end
`ifdef PG_BURST_EN
      chk("burst_syncs", syncs, 3);
      chk("burst_busy_len", last, 15);
`else
      chk("burst_syncs", syncs, 6);
      chk("burst_busy_len", last, 30);
`endif
      stop_and_idle();
    end
    // asynchronous reset while a pulse is high
    cfg(9, 0);
    set_ch(0, 2, 5);
    start_run();
    for (int n = 0; n < 20 && !bus.o_pulse[0]; n++) cyc();
    chk("rst_pre_pulse", int'(bus.o_pulse[0]), 1);
    #1 res_n = 1'b0;
    #1 chk("rst_async_outputs", obs(), 0);
    #1 res_n = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("rst_post_idle", obs(), 0);
    // random runs against a whole-waveform model
    for (int r = 0; r < 20; r++) begin
      int p, b, beff, per, k_per, stop_at, l;
      p = $urandom_range(0, 12);
      b = $urandom_range(0, 4);
      stop_at = $urandom_range(0, 1) ? $urandom_range(1, 60) : 0;
      cfg(p, b);
      for (int k = 0; k < NUM_CH; k++) begin
        rs[k] = $urandom_range(0, p + 3);
        re[k] = $urandom_range(0, p + 3);
        set_ch(k, rs[k], re[k]);
      end
`ifdef PG_BURST_EN
      beff = b;
`else
      beff = 0;
`endif
      per = p + 1;
      k_per = 100000;
      if (beff != 0) k_per = beff;
      if (stop_at != 0 && (stop_at - 1) / per + 1 < k_per) k_per = (stop_at - 1) / per + 1;
      l = k_per * per;
      start_run();
      for (int j = 1; j <= 60; j++) begin
        bit live;
        int c, pm;
        live = j >= 2 && j - 1 <= l;
        c = (j - 2 + per) % per;
        pm = 0;
        for (int k = 0; k < NUM_CH; k++)
          if (live && win(c, rs[k], re[k])) pm |= 1 << k;
        chk($sformatf("rand%0d_j%0d", r, j), obs(), pack(j == 1, j <= l, live && c == 0, pm));
        bus.i_stop = j == stop_at;
        bus.i_start = j <= l && $urandom_range(0, 7) == 0;
        bus.i_period = CNT_W'($urandom_range(0, 30));
        bus.i_st = {4{CNT_W'($urandom_range(0, 30))}};
        bus.i_end = {4{CNT_W'($urandom_range(0, 30))}};
        cyc();
      end
      bus.i_start = 1'b0;
      bus.i_stop = 1'b0;
      stop_and_idle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pg_multi_core.md
# pg_multi_core

Parametrised multi-channel pulse generation core, the successor to the fixed 4-channel / 16-bit pulse path of the Tang-Nano pulse generator. It runs in the `clk100m` domain behind `reg_map` and needs no separate period counter instance. It generates `NUM_CH` pulse trains from one shared period counter. New features:
- run/stop control
- finite bursts
- wrap-around pulse windows
- glitch-free shadow-register updates applied only at period boundaries

## Interface
- `NUM_CH`, 4, number of pulse channels (1..16)
- `CNT_W`, 24, width of period, start and end values (8..32)

Clock and reset: one clock; reset is asynchronous and active-low.
- `i_clk` in 1 — core clock (100 MHz)
- `i_res_n` in 1 — asynchronous active-low reset
- `i_start` in 1 — start request, 1-cycle pulse
- `i_stop` in 1 — graceful stop request, 1-cycle pulse
- `i_update` in 1 — request to load the config inputs into the shadow registers, 1-cycle pulse
- `i_period` in CNT_W — period length minus 1
- `i_burst_len` in 16 — number of periods per run; 0 = continuous
- `i_st` in NUM_CH*CNT_W — per-channel start count; channel k uses `[k*CNT_W +: CNT_W]`
- `i_end` in NUM_CH*CNT_W — per-channel end count, same packing as `i_st`
- `o_pulse` out NUM_CH — registered pulse outputs
- `o_sync` out 1 — 1-cycle strobe aligned with the first output cycle of each period
- `o_busy` out 1 — high while in RUN
- `o_upd_ack` out 1 — 1-cycle strobe; shadow registers were loaded

## Operation
- Shadow registers hold `period_s`, `burst_s`, `st_s[k]` and `end_s[k]`. The generator uses only the shadow values, never the live inputs.
- **States:**
  - IDLE: `cnt` = 0; outputs low.
  - RUN: `cnt` counts 0..`period_s`, then wraps to 0.
- **IDLE → RUN:** on `i_start`. Shadows load from the inputs, `cnt` = 0, `pcnt` (period count) = 0, and `o_upd_ack` pulses.
- **In RUN:**
  - `i_start` is ignored.
  - `i_stop` sets `stop_pend`.
- **At wrap** (`cnt` == `period_s`):
  - `pcnt` increments.
  - Go to IDLE if `stop_pend` is set, or if `burst_s` != 0 and `pcnt`+1 == `burst_s`.
  - If `upd_pend` is set, load the shadows and pulse `o_upd_ack`. This also happens on the wrap that goes to IDLE.
- **`i_update`:**
  - In IDLE: load the shadows immediately (ack the next cycle).
  - In RUN: set `upd_pend`.
  - Repeated requests before the wrap merge into one load, which uses the input values at the wrap cycle.
- **`i_stop`:** ignored in IDLE. If `i_start` and `i_stop` arrive together in IDLE, the start is taken and the stop is dropped.
- **Window per channel** (compared combinationally, then registered):
  - `st_s` < `end_s`: high when `st_s` ≤ `cnt` < `end_s`.
  - `st_s` > `end_s` (wrap-around): high when `cnt` ≥ `st_s` or `cnt` < `end_s`.
  - `st_s` == `end_s`: always low.
  - Values above `period_s` never match. The window is unsigned and `CNT_W` wide; `period_s` = 0 gives a 1-cycle period.
- **Reset:** `o_pulse` = 0, `o_sync` = 0, `o_busy` = 0, `o_upd_ack` = 0. The state is IDLE, all shadows are 0, and the pending flags are cleared.
- **Reset mid-run:** all outputs drop asynchronously and the pending requests are lost.

## Timing
- `i_start` sampled at cycle t:
  - RUN with `cnt` = 0 at t+1.
  - `o_busy` = 1 from t+1.
  - `o_upd_ack` at t+1.
  - First `o_pulse`/`o_sync` cycle at t+2.
- Output latency is 1 cycle from `cnt`. `o_sync` is high in the cycle after `cnt` == 0.
- Period = `period_s`+1 cycles exactly, with no dead cycle at the wrap.
- The last RUN cycle is the final wrap cycle; `o_busy` = 0 the cycle after it. `o_pulse` reflects that final `cnt` for one more cycle, then goes low.
- New shadow values take effect at `cnt` = 0 of the next period. `o_upd_ack` is high in that same cycle.

## Configuration
- `PG_BURST_EN` defined:
  - `i_burst_len` is honoured as above.
  - `pcnt` is a 16-bit counter.
- `PG_BURST_EN` undefined:
  - `burst_s` and `pcnt` are not implemented.
  - `i_burst_len` is ignored.
  - RUN is continuous until `i_stop`.

## Test plan
- **Basic run:** `NUM_CH`=4, period=9, ch0 st=2/end=5, `i_start`. → `o_pulse[0]` is high for 3 cycles of every 10. `o_sync` appears every 10 cycles, and the first one is at t+2.
- **Wrap-around and degenerate windows:** ch1 st=8/end=2 → ch1 is high for 4 cycles (`cnt` 8,9,0,1). ch2 st=end=4 → ch2 stays low. ch3 st=12 > period → ch3 stays low.
- **Burst:** burst_len=3, period=4. → Exactly 3 `o_sync` strobes; `o_busy` falls 15 cycles after entering RUN. With `PG_BURST_EN` undefined, the run is continuous.
- **Update mid-run:** `i_update` at `cnt`=3 with new period=19 and st0=0/end0=10. → The old waveform finishes, then `o_upd_ack` and the new 20-cycle period start together. There is no partial pulse.
- **Stop and simultaneous events:** `i_stop` at `cnt`=1 with period=9 → 8 more cycles run, then IDLE. `i_start`+`i_stop` together in IDLE → enters RUN and keeps running.
- **Reset mid-run:** assert `i_res_n`=0 with `o_pulse[0]`=1. → All outputs are 0 immediately. After release the core is in IDLE and `o_busy`=0.
